// File: rtl/complex_div_pkg.sv
// complex_div_pkg: shared constants, FSM state type and width helpers for
// the complex divider. The multiplier constants give the product width used
// by the numerator and denominator arithmetic.
package complex_div_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int FRAC_DEF  = 12;
    localparam int MUL_W_DEF = 2 * IN_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIV,
        DONE
    } state_t;

    // Signed numerator (ac+bd, bc-ad) / unsigned denominator (c^2+d^2) width
    function automatic int sum_w(input int in_w);
        return 2 * in_w + 1;
    endfunction

    // Numerator width after scaling by 2^frac (NUM_W)
    function automatic int num_w(input int in_w, input int frac);
        return 2 * in_w + 1 + frac;
    endfunction

    // Width of a down-counter that holds the value 'steps'
    function automatic int cnt_w(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/complex_div_udiv.sv
// udiv_seq: unsigned restoring divider, one quotient bit per cycle.
//   start    : loads dividend/divisor and begins Q_W steps
//   dividend : DVD_W-bit unsigned dividend
//   divisor  : DVS_W-bit unsigned divisor
//   quotient : Q_W-bit quotient (valid while done = 1)
//   done     : set after the last step, cleared by the next start
// The caller must guarantee quotient < 2^Q_W; otherwise quotient is
// meaningless.
module udiv_seq
    import complex_div_pkg::*;
#(
    parameter int DVD_W = 45,
    parameter int DVS_W = 33,
    parameter int Q_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [Q_W-1:0]   quotient,
    output logic             done
);

    localparam int RW = ((DVD_W > DVS_W) ? DVD_W : DVS_W) + Q_W;
    localparam int CW = cnt_w(Q_W);

    logic [RW-1:0] rem;
    logic [RW-1:0] dsh;
    logic [RW-1:0] dvd_ext;
    logic [RW-1:0] dvs_ext;
    logic [CW-1:0] cnt;
    logic          busy;

    assign dvd_ext = RW'(dividend);
    assign dvs_ext = RW'(divisor);

    // The divisor is pre-shifted to the top quotient bit position and walks
    // right one place per step, so the remainder never needs shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsh      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem      <= dvd_ext;
            dsh      <= dvs_ext << (Q_W - 1);
            cnt      <= CW'(Q_W);
            busy     <= 1'b1;
            done     <= 1'b0;
            quotient <= '0;
        end else if (busy) begin
            if (rem >= dsh) begin
                rem      <= rem - dsh;
                quotient <= {quotient[Q_W-2:0], 1'b1};
            end else begin
                quotient <= {quotient[Q_W-2:0], 1'b0};
            end
            dsh <= dsh >> 1;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/complex_div.sv
// complex_div: sequential complex division z = x / y with FRAC fractional
// bits in the quotient, truncation toward zero and saturation.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid / in_ready     : input handshake (ready only in IDLE)
//   re_x, im_x, re_y, im_y  : signed operands
//   out_valid / out_ready   : result handshake (valid only in DONE)
//   re_z, im_z              : signed quotient, held until the next result
//   div0                    : y == 0 (quotient forced to zero)
//   ovf                     : at least one component saturated
module complex_div
    import complex_div_pkg::*;
#(
    parameter int IN_W = IN_W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] re_x,
    input  logic signed [IN_W-1:0] im_x,
    input  logic signed [IN_W-1:0] re_y,
    input  logic signed [IN_W-1:0] im_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IN_W-1:0] re_z,
    output logic signed [IN_W-1:0] im_z,
    output logic                   div0,
    output logic                   ovf
);

    localparam int PROD_W = 2 * IN_W;
    localparam int SUM_W  = sum_w(IN_W);
    localparam int NUM_W  = num_w(IN_W, FRAC);
    localparam int CMP_W  = NUM_W + IN_W;

    localparam logic signed [IN_W-1:0] SAT_POS = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_NEG = {1'b1, {(IN_W-2){1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic signed [IN_W-1:0]   a_q, b_q, c_q, d_q;
    logic signed [PROD_W-1:0] p_ac, p_bd, p_bc, p_ad, p_cc, p_dd;
    logic signed [SUM_W-1:0]  sum_re, sum_im;
    logic [SUM_W-1:0]         den, mag_re, mag_im;
    logic [NUM_W-1:0]         num_re, num_im;
    logic [CMP_W-1:0]         den_lim;
    logic                     pre_ovf_re, pre_ovf_im, pre_div0;
    logic                     neg_re_q, neg_im_q, ovf_re_q, ovf_im_q, div0_q;
    logic [IN_W-1:0]          q_re, q_im;
    logic                     done_re, done_im;
    logic                     accept, start, finish;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign start     = (state == LOAD);
    assign finish    = (state == DIV) && done_re && done_im;

    // LOAD-stage arithmetic on the captured operands
    always_comb begin
        p_ac   = PROD_W'(a_q) * PROD_W'(c_q);
        p_bd   = PROD_W'(b_q) * PROD_W'(d_q);
        p_bc   = PROD_W'(b_q) * PROD_W'(c_q);
        p_ad   = PROD_W'(a_q) * PROD_W'(d_q);
        p_cc   = PROD_W'(c_q) * PROD_W'(c_q);
        p_dd   = PROD_W'(d_q) * PROD_W'(d_q);
        sum_re = SUM_W'(p_ac) + SUM_W'(p_bd);
        sum_im = SUM_W'(p_bc) - SUM_W'(p_ad);
        den    = SUM_W'($unsigned(p_cc)) + SUM_W'($unsigned(p_dd));
        mag_re = sum_re[SUM_W-1] ? $unsigned(-sum_re) : $unsigned(sum_re);
        mag_im = sum_im[SUM_W-1] ? $unsigned(-sum_im) : $unsigned(sum_im);
        num_re = {mag_re, {FRAC{1'b0}}};
        num_im = {mag_im, {FRAC{1'b0}}};
        // |q| >= 2^(IN_W-1)  <=>  |num| >= den * 2^(IN_W-1); checking here
        // also keeps the divider's quotient inside IN_W bits.
        den_lim    = CMP_W'(den) << (IN_W - 1);
        pre_ovf_re = CMP_W'(num_re) >= den_lim;
        pre_ovf_im = CMP_W'(num_im) >= den_lim;
        pre_div0   = (den == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = LOAD;
            LOAD: state_nxt = DIV;
            DIV:  if (done_re && done_im) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and LOAD-stage flags. The numerators and denominator
    // are registered inside the dividers, which sample them on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            neg_re_q <= 1'b0;
            neg_im_q <= 1'b0;
            ovf_re_q <= 1'b0;
            ovf_im_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= re_x;
                b_q <= im_x;
                c_q <= re_y;
                d_q <= im_y;
            end
            if (start) begin
                neg_re_q <= sum_re[SUM_W-1];
                neg_im_q <= sum_im[SUM_W-1];
                ovf_re_q <= pre_ovf_re;
                ovf_im_q <= pre_ovf_im;
                div0_q   <= pre_div0;
            end
        end
    end

    udiv_seq #(
        .DVD_W(NUM_W),
        .DVS_W(SUM_W),
        .Q_W  (IN_W)
    ) u_div_re (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dividend(num_re),
        .divisor (den),
        .quotient(q_re),
        .done    (done_re)
    );

    udiv_seq #(
        .DVD_W(NUM_W),
        .DVS_W(SUM_W),
        .Q_W  (IN_W)
    ) u_div_im (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dividend(num_im),
        .divisor (den),
        .quotient(q_im),
        .done    (done_im)
    );

    // Result registers load only on the DIV -> DONE transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_z <= '0;
            im_z <= '0;
            div0 <= 1'b0;
            ovf  <= 1'b0;
        end else if (finish) begin
            div0 <= div0_q;
            ovf  <= !div0_q && (ovf_re_q || ovf_im_q);
            if (div0_q) begin
                re_z <= '0;
                im_z <= '0;
            end else begin
                if (ovf_re_q) re_z <= neg_re_q ? SAT_NEG : SAT_POS;
                else          re_z <= neg_re_q ? -$signed(q_re) : $signed(q_re);
                if (ovf_im_q) im_z <= neg_im_q ? SAT_NEG : SAT_POS;
                else          im_z <= neg_im_q ? -$signed(q_im) : $signed(q_im);
            end
        end
    end

endmodule

// File: tb/tb_complex_div.sv
// tb_complex_div: directed self-checking bench for complex_div
// (IN_W = 16, FRAC = 12) with hand-computed expected quotients.
module tb_complex_div;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] re_x, im_x, re_y, im_y;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] re_z, im_z;
    logic               div0;
    logic               ovf;

    int total = 0;
    int bad   = 0;
    int last_re = 0;
    int last_im = 0;

    always #5 clk = ~clk;

    complex_div #(
        .IN_W(16),
        .FRAC(12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .re_x     (re_x),
        .im_x     (im_x),
        .re_y     (re_y),
        .im_y     (im_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .re_z     (re_z),
        .im_z     (im_z),
        .div0     (div0),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input int a, input int b,
                          input int c, input int d, input int er,
                          input int ei, input int ed, input int eo,
                          input int hold, input bit early_ready);
        int n;
        @(negedge clk);
        re_x      = 16'(a);
        im_x      = 16'(b);
        re_y      = 16'(c);
        im_y      = 16'(d);
        in_valid  = 1'b1;
        out_ready = early_ready;
        check({tag, "/rdy"}, in_ready, 1);
        @(posedge clk);
        #1;
        // Junk offered while busy must be ignored
        re_x = 16'sh5a5a;
        im_x = -16'sd7;
        re_y = 16'sd0;
        im_y = 16'sd0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            if (n == 4) begin
                check({tag, "/busy_rdy"}, in_ready, 0);
                check({tag, "/keep_re"}, re_z, last_re);
                check({tag, "/keep_im"}, im_z, last_im);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check({tag, "/lat"}, n, 18);
        check({tag, "/re"}, re_z, er);
        check({tag, "/im"}, im_z, ei);
        check({tag, "/div0"}, div0, ed);
        check({tag, "/ovf"}, ovf, eo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "/hold_vld"}, out_valid, 1);
            check({tag, "/hold_rdy"}, in_ready, 0);
            check({tag, "/hold_re"}, re_z, er);
            check({tag, "/hold_im"}, im_z, ei);
            check({tag, "/hold_div0"}, div0, ed);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "/hs_vld"}, out_valid, 0);
        check({tag, "/hs_rdy"}, in_ready, 1);
        check({tag, "/retain_re"}, re_z, er);
        last_re = er;
        last_im = ei;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        re_x      = '0;
        im_x      = '0;
        re_y      = '0;
        im_y      = '0;
        #2;
        rst_n = 1'b0;
        #10;
        check("rst/in_ready", in_ready, 1);
        check("rst/out_valid", out_valid, 0);
        check("rst/re_z", re_z, 0);
        check("rst/im_z", im_z, 0);
        check("rst/div0", div0, 0);
        check("rst/ovf", ovf, 0);

        // Release just after an edge: the very next rising edge accepts
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("unit",      4096,   0, 4096,     0,   4096,     0, 0, 0, 0, 1'b0);
        run_op("rot",       4096, 4096, 4096, -4096,     0,  4096, 0, 0, 0, 1'b1);
        run_op("trunc",       -1,   0,    3,     0,  -1365,     0, 0, 0, 0, 1'b0);
        run_op("sat_pos",  32767,   0,    1,     0,  32767,     0, 0, 1, 0, 1'b0);
        run_op("sat_neg", -32768,   0,    1,     0, -32767,     0, 0, 1, 0, 1'b0);
        run_op("div0",      1234, -77,    0,     0,      0,     0, 1, 0, 5, 1'b0);
        run_op("mixed",        3,   4,    1,     2,   9011, -1638, 0, 0, 0, 1'b1);
        run_op("sat_both",   100, -200,   0,     1, -32767, -32767, 0, 1, 0, 1'b0);
        run_op("max_exact", 32767,  0, 4096,     0,  32767,     0, 0, 0, 0, 1'b0);
        run_op("edge_ovf",     8,   0,    1,     0,  32767,     0, 0, 1, 0, 1'b0);
        run_op("min_ovf", -32768,   0, 4096,     0, -32767,     0, 0, 1, 0, 1'b0);

        // Reset pulse in the middle of DIV aborts the operation
        @(negedge clk);
        re_x      = 16'sd3;
        im_x      = 16'sd4;
        re_y      = 16'sd1;
        im_y      = 16'sd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort/out_valid", out_valid, 0);
        check("abort/in_ready", in_ready, 1);
        check("abort/re_z", re_z, 0);
        check("abort/ovf", ovf, 0);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        check("abort/no_result", seen, 0);
        out_ready = 1'b0;
        last_re   = 0;
        last_im   = 0;
        run_op("after_rst", 3, 4, 1, 2, 9011, -1638, 0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
